// File: rtl/value_seq_gen.sv
// Value sequence generator: after a start and a short warm-up, emits an up/down
// stepped WIDTH-bit stream over a valid/ready handshake, bounded or free-running.
module value_seq_gen #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] init_val,
  input  logic [CNT_W-1:0] num_samples,
  output logic [WIDTH-1:0] out_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             wrapped,
  output logic [1:0]       state_dbg
);

  // Handshake: a sample transfers on any posedge where out_valid && out_ready.
  // out_valid never drops while waiting for ready, and out_val is stable until taken.

  localparam int WW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] out_val_q,   out_val_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             wrapped_q,   wrapped_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WW-1:0]    warm_q,      warm_d;
  logic             up_q,        up_d;
  logic             sat_q,       sat_d;
  logic [WIDTH-1:0] step_q,      step_d;
  logic [CNT_W-1:0] num_q,       num_d;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH:0]   ext_w;
  logic             ovf;
  logic [WIDTH-1:0] next_val;
  logic             hs;
  logic             last_hs;

  // Bit WIDTH of the extended result is the carry (up) or the borrow (down).
  always_comb begin
    sum_w    = {1'b0, out_val_q} + {1'b0, step_q};
    diff_w   = {1'b0, out_val_q} - {1'b0, step_q};
    ext_w    = up_q ? sum_w : diff_w;
    ovf      = ext_w[WIDTH];
    next_val = ext_w[WIDTH-1:0];
    if (ovf && sat_q) begin
      next_val = up_q ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    end
  end

  assign hs      = out_valid_q && out_ready;
  assign last_hs = hs && (num_q != '0) && (cnt_q == num_q - CNT_W'(1));

  always_comb begin
    state_d     = state_q;
    out_val_d   = out_val_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wrapped_d   = 1'b0;
    cnt_d       = cnt_q;
    warm_d      = warm_q;
    up_d        = up_q;
    sat_d       = sat_q;
    step_d      = step_q;
    num_d       = num_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          up_d      = up_dn;
          sat_d     = sat_mode;
          step_d    = step;
          num_d     = num_samples;
          out_val_d = init_val;
          warm_d    = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_WARMUP;
        end
      end
      S_WARMUP: begin
        if (abort) begin
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (warm_q == WW'(HOLD_CYCLES - 1)) begin
          out_valid_d = 1'b1;
          state_d     = S_RUN;
        end else begin
          warm_d = warm_q + WW'(1);
        end
      end
      S_RUN: begin
        if (abort) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end else if (last_hs) begin
          // The final sample leaves out_val untouched so it still shows what was sent.
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
          state_d     = S_DONE;
        end else if (hs) begin
          cnt_d     = cnt_q + CNT_W'(1);
          out_val_d = next_val;
          wrapped_d = ovf;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_val_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wrapped_q   <= 1'b0;
      cnt_q       <= '0;
      warm_q      <= '0;
      up_q        <= 1'b0;
      sat_q       <= 1'b0;
      step_q      <= '0;
      num_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_val_q   <= out_val_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wrapped_q   <= wrapped_d;
      cnt_q       <= cnt_d;
      warm_q      <= warm_d;
      up_q        <= up_d;
      sat_q       <= sat_d;
      step_q      <= step_d;
      num_q       <= num_d;
    end
  end

  assign out_val   = out_val_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wrapped   = wrapped_q;
  assign state_dbg = state_q;

endmodule

// File: doc/value_seq_gen.md
Name: value_seq_gen

Overview:
- Upstream stimulus/source stage that produces the 4-bit value stream consumed by the downstream clock-muxed output stage (`in_val` there).
- Replaces the ad-hoc bench counter with a synthesizable generator:
  - post-start warm-up hold, modelled on the two-cycle reset hold used in bring-up;
  - programmable up/down stepping with wrap or saturate arithmetic;
  - valid/ready output handshake;
  - bounded or free-running sample count.

Parameters:
- WIDTH, 4, data width of out_val, step and init_val.
- HOLD_CYCLES, 2, warm-up cycles between start acceptance and first valid sample (≥1).
- CNT_W, 8, width of the sample counter and of num_samples.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset; one clock; reset polarity and synchronicity fixed.
- start  in  1  begin a sequence; sampled only in IDLE.
- abort  in  1  terminate the sequence; effective in any non-IDLE state.
- up_dn  in  1  1 = add step, 0 = subtract step.
- sat_mode  in  1  1 = saturate at 0 / 2^WIDTH-1, 0 = wrap modulo 2^WIDTH.
- step  in  WIDTH  increment magnitude.
- init_val  in  WIDTH  first sample value.
- num_samples  in  CNT_W  samples to emit; 0 = free-running.
- out_val  out  WIDTH  current sample.
- out_valid  out  1  out_val is valid.
- out_ready  in  1  consumer accepts out_val this cycle.
- busy  out  1  high in WARMUP and RUN.
- done  out  1  one-cycle pulse after the final handshake.
- wrapped  out  1  one-cycle pulse when the update overflowed or underflowed (wrap or clamp).

Behaviour:

Reset (rst_n low, asynchronous, no clock needed):
- state = IDLE.
- out_val = 0, out_valid = 0, busy = 0, done = 0, wrapped = 0.
- Sample counter = 0, warm-up counter = 0.
- Reset mid-operation discards the sequence immediately; no done pulse.

FSM states: IDLE, WARMUP, RUN, DONE.
- IDLE:
  - If start is high at posedge T: latch up_dn, sat_mode, step, num_samples; out_val <= init_val; warm-up counter <= 0; enter WARMUP at T+1.
- WARMUP:
  - out_valid = 0, busy = 1.
  - After HOLD_CYCLES cycles in WARMUP, enter RUN, so out_valid first rises at T+1+HOLD_CYCLES.
- RUN:
  - out_valid = 1, busy = 1.
  - Handshake = out_valid && out_ready.
  - On a handshake: sample counter++; out_val <= next value at the same edge.
  - Without a handshake: out_val, out_valid and the counter hold.
- Final sample: a handshake with counter == num_samples-1 and num_samples != 0:
  - Enter DONE; out_valid = 0; out_val keeps the last emitted value (no update).
- DONE:
  - done = 1, busy = 0 for exactly one cycle; then IDLE.
  - Counter is cleared on entry to IDLE.
- abort high in WARMUP or RUN:
  - IDLE at the next edge; out_valid = 0; no done pulse.
  - abort has priority over a simultaneous handshake; that handshake is not counted.
- Configuration inputs are ignored outside the start cycle.
- start while not IDLE is ignored.

Arithmetic:
- Compute on WIDTH+1 bits.
- Up: sum = out_val + step. Down: diff = out_val - step.
- Carry-out (up) or borrow (down) defines overflow.
- Wrap mode: keep the low WIDTH bits.
- Saturate mode: clamp to 2^WIDTH-1 (up) or 0 (down).
- wrapped pulses in the cycle after the handshake that produced overflow, i.e. aligned with the updated out_val, in either mode.
- step = 0: value constant; samples still counted.

Free-run (num_samples = 0):
- Never enters DONE; the counter wraps silently at 2^CNT_W.
- Exit only via abort or reset.

Test Plan:
1. Basic up-count:
   - Stimulus: init_val = 0, step = 1, up, wrap, num_samples = 5, out_ready = 1, start pulse at cycle 0.
   - Response: out_valid rises at cycle 3; out_val = 0,1,2,3,4 on cycles 3–7; done = 1 at cycle 8 only; busy low from cycle 8.
2. Wrap:
   - Stimulus: init_val = 14, step = 1, up, wrap, num_samples = 4.
   - Response: out_val = 14,15,0,1; wrapped high only in the cycle out_val changes 15→0.
3. Saturating down:
   - Stimulus: init_val = 2, step = 3, down, sat, num_samples = 3.
   - Response: out_val = 2,0,0; wrapped pulses on both updates; done after the third handshake.
4. Backpressure:
   - Stimulus: init_val = 5, step = 2, up, num_samples = 3, out_ready pattern 0,1,0,0,1,1 from the first valid cycle.
   - Response: out_val holds 5 for cycles 0–1, then 7 for cycles 2–4, then 9 at cycle 5; exactly 3 handshakes; done one cycle after the last.
5. Abort and async reset:
   - Stimulus A: abort during RUN after 2 handshakes.
   - Response A: IDLE next edge, out_valid = 0, no done.
   - Stimulus B: rst_n low between clock edges mid-RUN.
   - Response B: out_val = 0, out_valid = 0, busy = 0 immediately.
   - Also check: start pulsed while busy is ignored.
6. Free-run:
   - Stimulus: num_samples = 0, init_val = 0, step = 1, 20 handshakes.
   - Response: out_val = 0..15,0,1,2,3; no done; wrapped once at 15→0; abort returns the block to IDLE.
